pmem_responder: RTL and testbench

- Physical-memory-side responder for the line-based pmem handshake driven by the cache controller: pmem_read/pmem_write, pmem_address, pmem_wdata in; pmem_rdata, pmem_resp out.
- Holds a line-granular storage array and answers each request after a programmable number of wait cycles.
- Sits below the cache in the memory hierarchy. It stands in for main memory in synthesis-level system tests and exercises the controller's wait, evict and refill paths with realistic latency.

---
 rtl/pmem_responder.sv | 127 ++++++++++++
 tb/tb_pmem_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pmem_responder.sv
// Line-granular memory responder for the cache pmem handshake.
// Answers each read/write after LATENCY wait cycles; counts completions and flags read+write collisions.
//
// state | meaning
// IDLE  | waiting for pmem_read/pmem_write
// BUSY  | request latched, counting down the wait cycles
// RESP  | pmem_resp high for one cycle; write commits on exit
module pmem_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_BITS  = 128,
  parameter int INDEX_BITS = 6,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] pmem_address,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [LINE_BITS-1:0]  pmem_wdata,
  output logic [LINE_BITS-1:0]  pmem_rdata,
  output logic                  pmem_resp,
  output logic                  proto_err,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_t                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   op_wr_q, op_wr_d;
  logic [INDEX_BITS-1:0]  idx_q, idx_d;
  logic [LINE_BITS-1:0]   wdata_q, wdata_d;
  logic [LINE_BITS-1:0]   rdata_q, rdata_d;
  logic                   proto_q, proto_d;
  logic [15:0]            rd_cnt_q, rd_cnt_d;
  logic [15:0]            wr_cnt_q, wr_cnt_d;
  logic                   mem_we;
  logic [LINE_BITS-1:0]   mem_q [2**INDEX_BITS];

  // Offset and upper address bits alias by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{pmem_address[ADDR_WIDTH-1:INDEX_BITS+4], pmem_address[3:0]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_wr_d  = op_wr_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    proto_d  = proto_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    mem_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pmem_read || pmem_write) begin
          state_d = BUSY;
          cnt_d   = CNT_INIT;
          op_wr_d = pmem_write;
          idx_d   = pmem_address[INDEX_BITS+3:4];
          wdata_d = pmem_wdata;
          if (pmem_read && pmem_write) proto_d = 1'b1;
        end
      end
      BUSY: begin
        if (!pmem_read && !pmem_write) begin
          state_d = IDLE;
        end else if (cnt_q == 8'd0) begin
          state_d = RESP;
          if (!op_wr_q) rdata_d = mem_q[idx_q];
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (op_wr_q) begin
          mem_we = 1'b1;
          if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
        end else if (rd_cnt_q != 16'hFFFF) begin
          rd_cnt_d = rd_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      op_wr_q  <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      proto_q  <= 1'b0;
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_wr_q  <= op_wr_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      proto_q  <= proto_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q] <= wdata_q;
  end

  assign pmem_resp  = (state_q == RESP);
  assign pmem_rdata = rdata_q;
  assign proto_err  = proto_q;
  assign rd_count   = rd_cnt_q;
  assign wr_count   = wr_cnt_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Self-checking bench for pmem_responder: directed vector table, randomized traffic
// against a line-array reference model, and an asynchronous reset abort sequence.
module tb_pmem_responder;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  pmem_address = '0;
  logic         pmem_read = 1'b0;
  logic         pmem_write = 1'b0;
  logic [127:0] pmem_wdata = '0;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic         proto_err;
  logic [15:0]  rd_count;
  logic [15:0]  wr_count;

  pmem_responder #(.ADDR_WIDTH(16), .LINE_BITS(128), .INDEX_BITS(6), .LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .pmem_address(pmem_address), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp), .proto_err(proto_err), .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model: line array, completion counters, sticky error, last read line
  logic [127:0] mem_m [64];
  logic [127:0] exp_rdata = '0;
  int           rd_m = 0;
  int           wr_m = 0;
  bit           proto_m = 1'b0;
  bit           in_resp = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chki("idle_resp", int'(pmem_resp), 0);
      chk("rdata_hold", pmem_rdata, exp_rdata);
      in_resp = 1'b0;
    end
  endtask

  // Issue one request; wk>0 withdraws it at the start of BUSY cycle wk.
  // Returns in the RESP cycle (resp_at = cycle number) or resp_at = -1 when no response occurs.
  task automatic txn(input logic rd, input logic wr, input logic [15:0] addr,
                     input logic [127:0] wd, input int wk, output int resp_at);
    int idx;
    idx = int'(addr[9:4]);
    pmem_read = rd; pmem_write = wr; pmem_address = addr; pmem_wdata = wd;
    resp_at = -1;
    if (in_resp) begin
      @(posedge clk); #1;
      chki("resp_gap", int'(pmem_resp), 0);
      in_resp = 1'b0;
    end
    @(posedge clk); #1;
    if (rd && wr) proto_m = 1'b1;
    chki("rd_count", int'(rd_count), rd_m);
    chki("wr_count", int'(wr_count), wr_m);
    chki("proto_err", int'(proto_err), int'(proto_m));
    for (int k = 1; k <= L + 1; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (k == wk) begin pmem_read = 1'b0; pmem_write = 1'b0; end
      if (wk == 0 && k == L + 1) begin
        chki("resp_at_latency", int'(pmem_resp), 1);
        if (pmem_resp) resp_at = cyc;
        if (!wr) begin
          exp_rdata = mem_m[idx];
          chk("read_data", pmem_rdata, exp_rdata);
          if (rd_m < 65535) rd_m++;
        end else begin
          chk("write_rdata_hold", pmem_rdata, exp_rdata);
          mem_m[idx] = wd;
          if (wr_m < 65535) wr_m++;
        end
        in_resp = 1'b1;
        pmem_read = 1'b0; pmem_write = 1'b0;
      end else begin
        chki("resp_early", int'(pmem_resp), 0);
        chk("rdata_busy_hold", pmem_rdata, exp_rdata);
      end
    end
  endtask

  typedef struct {
    logic         rd;
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] wd;
    int           wk;
    bit           exp_resp;
    bit           chk_data;
    logic [127:0] exp_data;
    int           gap;
  } vec_t;

  localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] DA = {16{8'hAA}};
  localparam logic [127:0] D5 = {16{8'h55}};
  localparam logic [127:0] DB = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] DX = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

  vec_t v[11];

  initial begin
    int r, prev;
    logic [127:0] pre;
    v[0]  = '{1'b0, 1'b1, 16'h0040, D1,   0, 1'b1, 1'b0, '0, 2};
    v[1]  = '{1'b1, 1'b0, 16'h0040, '0,   0, 1'b1, 1'b1, D1, 1};
    v[2]  = '{1'b0, 1'b1, 16'h0200, DA,   0, 1'b1, 1'b0, '0, 1};
    v[3]  = '{1'b0, 1'b1, 16'h0100, DB,   0, 1'b1, 1'b0, '0, 1};
    v[4]  = '{1'b1, 1'b0, 16'h0200, '0,   0, 1'b1, 1'b1, DA, 0};
    v[5]  = '{1'b1, 1'b0, 16'h0040, '0,   2, 1'b0, 1'b0, '0, 1};
    v[6]  = '{1'b0, 1'b1, 16'h0040, DX,   2, 1'b0, 1'b0, '0, 1};
    v[7]  = '{1'b1, 1'b0, 16'h0040, '0,   0, 1'b1, 1'b1, D1, 1};
    v[8]  = '{1'b1, 1'b1, 16'h0080, D5,   0, 1'b1, 1'b0, '0, 1};
    v[9]  = '{1'b1, 1'b0, 16'h0080, '0,   0, 1'b1, 1'b1, D5, 0};
    v[10] = '{1'b1, 1'b0, 16'h4040, '0,   0, 1'b1, 1'b1, D1, 0};
    for (int i = 0; i < 64; i++) mem_m[i] = '0;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chki("reset_resp", int'(pmem_resp), 0);
    chk("reset_rdata", pmem_rdata, '0);
    chki("reset_proto", int'(proto_err), 0);
    chki("reset_rd_count", int'(rd_count), 0);
    chki("reset_wr_count", int'(wr_count), 0);

    prev = -1;
    for (int i = 0; i < 11; i++) begin
      if (v[i].gap > 0) idle(v[i].gap);
      txn(v[i].rd, v[i].wr, v[i].addr, v[i].wd, v[i].wk, r);
      chki("vec_resp", int'(r >= 0), int'(v[i].exp_resp));
      if (v[i].chk_data && r >= 0) chk("vec_rdata", pmem_rdata, v[i].exp_data);
      if (v[i].gap == 0 && prev >= 0 && r >= 0) chki("b2b_spacing", r - prev, L + 2);
      prev = r;
    end
    idle(2);
    chki("proto_sticky", int'(proto_err), 1);
    chki("vec_rd_total", int'(rd_count), 5);
    chki("vec_wr_total", int'(wr_count), 4);

    // Fill every line so random reads have defined expectations.
    for (int i = 0; i < 64; i++)
      txn(1'b0, 1'b1, 16'(i << 4), {$urandom, $urandom, $urandom, $urandom}, 0, r);

    for (int n = 0; n < 80; n++) begin
      int op;
      int wk;
      op = $urandom_range(0, 9);
      wk = ($urandom_range(0, 6) == 0) ? $urandom_range(1, L) : 0;
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      txn(op < 5 || op == 9, op >= 5, 16'($urandom), {$urandom, $urandom, $urandom, $urandom}, wk, r);
      chki("rand_resp", int'(r >= 0), int'(wk == 0));
    end

    // Reset in the middle of a write must abort it without touching the line.
    idle(1);
    pre = mem_m[1];
    pmem_write = 1'b1; pmem_address = 16'h0010; pmem_wdata = ~pre;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chki("rst_resp", int'(pmem_resp), 0);
    chk("rst_rdata", pmem_rdata, '0);
    chki("rst_proto", int'(proto_err), 0);
    chki("rst_rd_count", int'(rd_count), 0);
    chki("rst_wr_count", int'(wr_count), 0);
    pmem_write = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rd_m = 0; wr_m = 0; proto_m = 1'b0; exp_rdata = '0; in_resp = 1'b0;
    txn(1'b1, 1'b0, 16'h0010, '0, 0, r);
    chk("rst_prewrite_data", pmem_rdata, pre);
    idle(2);
    chki("final_rd_count", int'(rd_count), 1);
    chki("final_wr_count", int'(wr_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
